// File: rtl/arm_decode_pkg.sv
// Shared types and constants for the ARMv4 family decode stage.
package arm_decode_pkg;
  localparam int FAM_W = 20;
  typedef logic [FAM_W-1:0] fam_t;

  localparam logic [4:0] FAM_DP_IMM   = 5'd0;
  localparam logic [4:0] FAM_DP_REG   = 5'd1;
  localparam logic [4:0] FAM_DP_RSH   = 5'd2;
  localparam logic [4:0] FAM_MUL      = 5'd3;
  localparam logic [4:0] FAM_MULL     = 5'd4;
  localparam logic [4:0] FAM_MRS      = 5'd5;
  localparam logic [4:0] FAM_MSR_IMM  = 5'd6;
  localparam logic [4:0] FAM_MSR_REG  = 5'd7;
  localparam logic [4:0] FAM_LDST_IMM = 5'd8;
  localparam logic [4:0] FAM_LDST_REG = 5'd9;
  localparam logic [4:0] FAM_HW_IMM   = 5'd10;
  localparam logic [4:0] FAM_HW_REG   = 5'd11;
  localparam logic [4:0] FAM_SWP      = 5'd12;
  localparam logic [4:0] FAM_LDM      = 5'd13;
  localparam logic [4:0] FAM_BRANCH   = 5'd14;
  localparam logic [4:0] FAM_UNDEF    = 5'd15;
  localparam logic [4:0] FAM_SWI      = 5'd16;
  localparam logic [4:0] FAM_CP_DATA  = 5'd17;
  localparam logic [4:0] FAM_CP_LDST  = 5'd18;
  localparam logic [4:0] FAM_BX       = 5'd19;

  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;
  localparam logic [3:0]  COND_NV    = 4'hF;

  typedef struct packed {
    logic [31:0] ir;
    fam_t        fam;
  } beat_t;
endpackage

// File: rtl/arm_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface arm_decode_if;
  import arm_decode_pkg::*;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  fam_t        out_family;
  logic [3:0]  out_cond;
  logic        out_nv;

  modport master (
    output in_valid, in_ir, out_ready,
    input  in_ready, out_valid, out_ir, out_family, out_cond, out_nv
  );
  modport slave (
    input  in_valid, in_ir, out_ready,
    output in_ready, out_valid, out_ir, out_family, out_cond, out_nv
  );
endinterface

// File: rtl/arm_family_decode.sv
// Combinational one-hot instruction-family classifier (cond field not needed).
module arm_family_decode
  import arm_decode_pkg::*;
#(
  parameter bit ENABLE_COPROC = 1'b1,
  parameter bit ENABLE_BX     = 1'b1
) (
  input  logic [27:0] ir,
  output fam_t        fam
);
  logic [4:0] idx;

  always_comb begin
    idx = FAM_UNDEF;
    unique case (ir[27:25])
      3'b000: begin
        if (ENABLE_BX && ir[27:4] == BX_PATTERN)                         idx = FAM_BX;
        else if (ir[24:22] == 3'b000 && ir[7:4] == 4'b1001)              idx = FAM_MUL;
        else if (ir[24:23] == 2'b01 && ir[7:4] == 4'b1001)               idx = FAM_MULL;
        else if (ir[24:23] == 2'b10 && ir[21:20] == 2'b00)
          idx = (ir[7:4] == 4'b1001) ? FAM_SWP : FAM_MRS;
        else if (ir[24:23] == 2'b10 && ir[21:20] == 2'b10 && !ir[4])     idx = FAM_MSR_REG;
        else if (!ir[4])                                                 idx = FAM_DP_REG;
        else if (!ir[7])                                                 idx = FAM_DP_RSH;
        else if (!ir[22])                                                idx = FAM_HW_REG;
        else                                                             idx = FAM_HW_IMM;
      end
      3'b001: idx = (ir[24:23] == 2'b10 && ir[21:20] == 2'b10) ? FAM_MSR_IMM : FAM_DP_IMM;
      3'b010: idx = FAM_LDST_IMM;
      3'b011: idx = ir[4] ? FAM_UNDEF : FAM_LDST_REG;
      3'b100: idx = FAM_LDM;
      3'b101: idx = FAM_BRANCH;
      3'b110: idx = ENABLE_COPROC ? FAM_CP_LDST : FAM_UNDEF;
      3'b111: begin
        if (ir[24])             idx = FAM_SWI;
        else if (ENABLE_COPROC) idx = FAM_CP_DATA;
        else                    idx = FAM_UNDEF;
      end
    endcase
    fam = FAM_W'(1) << idx;
  end
endmodule

// File: rtl/arm_decode_stage.sv
// Registered decode stage: output register + one skid entry, flush, undef counter.
module arm_decode_stage
  import arm_decode_pkg::*;
#(
  parameter bit ENABLE_COPROC = 1'b1,
  parameter bit ENABLE_BX     = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  arm_decode_if.slave      bus,
  output logic [CNT_W-1:0] undef_count
);
  beat_t in_beat, out_q, skid_q;
  logic  out_vld, skid_vld, accept, drain;

  arm_family_decode #(
    .ENABLE_COPROC(ENABLE_COPROC),
    .ENABLE_BX    (ENABLE_BX)
  ) u_dec (
    .ir (bus.in_ir[27:0]),
    .fam(in_beat.fam)
  );
  assign in_beat.ir = bus.in_ir;

  // skid_vld is a flop, so in_ready is registered by construction
  assign bus.in_ready = !skid_vld;
  assign accept       = bus.in_valid && !skid_vld;
  assign drain        = out_vld && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld     <= 1'b0;
      skid_vld    <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      undef_count <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (drain && out_q.fam[FAM_UNDEF] && undef_count != '1)
        undef_count <= undef_count + CNT_W'(1);
      if (!out_vld || bus.out_ready) begin
        // skid holds the older beat; accept cannot coincide with a full skid
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else if (accept) begin
          out_q   <= in_beat;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (accept) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = out_vld;
  assign bus.out_ir     = out_q.ir;
  assign bus.out_family = out_q.fam;
  assign bus.out_cond   = out_q.ir[31:28];
  assign bus.out_nv     = (out_q.ir[31:28] == COND_NV);
endmodule
